uart_sfr_ctrl: RTL and testbench

UART_SFR_CTRL -- requirements
Module: uart_sfr_ctrl

---
 rtl/uart_sfr_ctrl_if.sv | 28 ++
 rtl/uart_sfr_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uart_sfr_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_sfr_ctrl_if.sv
// ============================================================================
//  Module      : uart_sfr_ctrl_if
//  Description : CPU special-function-register bus between core and UART SFRs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_sfr_ctrl_if;
    logic [7:0] sfr_addr;
    logic       sfr_wr;
    logic       sfr_rd;
    logic [7:0] sfr_wdata;
    logic [7:0] sfr_rdata;
    logic       sfr_hit;
    logic       stall;

    modport master (
        output sfr_addr, sfr_wr, sfr_rd, sfr_wdata,
        input  sfr_rdata, sfr_hit, stall
    );

    modport slave (
        input  sfr_addr, sfr_wr, sfr_rd, sfr_wdata,
        output sfr_rdata, sfr_hit, stall
    );
endinterface

`default_nettype wire

// File: rtl/uart_sfr_ctrl.sv
// ============================================================================
//  Module      : uart_sfr_ctrl
//  Description : SCON/SBUF register block bridging CPU SFR bus to TX FIFO and
//                UART receive interrupt, with TX/RX flag state machines.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sfr_ctrl #(
    parameter logic [7:0]  SCON_ADDR = 8'h98,
    parameter logic [7:0]  SBUF_ADDR = 8'h99,
    parameter int unsigned ACK_CYC   = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    uart_sfr_ctrl_if.slave   sfr,
    output      logic [7:0]  fifo_wdata,
    output      logic        fifo_w_en,
    input  wire logic        fifo_full,
    input  wire logic        fifo_empty,
    input  wire logic [7:0]  rx_data,
    input  wire logic        rx_valid,
    output      logic        rx_ack,
    output      logic        uart_irq
);

    localparam int unsigned CNT_W = (ACK_CYC < 2) ? 1 : $clog2(ACK_CYC);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_CYC - 1);

    localparam int RI_BIT  = 0;
    localparam int TI_BIT  = 1;
    localparam int OVR_BIT = 2;
    localparam int REN_BIT = 4;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_ARM  = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_ACK  = 2'd1,
        RX_WAIT = 2'd2
    } rx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [7:0]       scon_q, scon_d;
    logic [7:0]       rbuf_q, rbuf_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic [7:0]       fifo_wdata_q, fifo_wdata_d;
    logic             fifo_w_en_q, fifo_w_en_d;

    logic w_scon_sel;
    logic w_sbuf_sel;
    logic w_sbuf_wr;
    logic w_push;
    logic w_ti_set;
    logic w_ri_set;
    logic w_ovr_set;

    // ------------------------------------------------------------------------
    // SFR decode, read mux and write-side flow control
    // ------------------------------------------------------------------------
    always_comb begin
        w_scon_sel = (sfr.sfr_addr == SCON_ADDR);
        w_sbuf_sel = (sfr.sfr_addr == SBUF_ADDR);
        w_sbuf_wr  = sfr.sfr_wr && w_sbuf_sel;
        w_push     = w_sbuf_wr && !fifo_full;

        sfr.sfr_hit   = w_scon_sel || w_sbuf_sel;
        sfr.stall     = w_sbuf_wr && fifo_full;
        sfr.sfr_rdata = 8'h00;
        if (sfr.sfr_rd && w_scon_sel) begin
            sfr.sfr_rdata = scon_q;
        end else if (sfr.sfr_rd && w_sbuf_sel) begin
            sfr.sfr_rdata = rbuf_q;
        end

        fifo_w_en_d  = w_push;
        fifo_wdata_d = w_push ? sfr.sfr_wdata : fifo_wdata_q;
    end

    // ------------------------------------------------------------------------
    // TX FSM: TI fires once the FIFO has gone non-empty and drained again.
    // A push still in flight (fifo_w_en_q) has not reached fifo_empty yet,
    // so it must also hold TX_BUSY.
    // ------------------------------------------------------------------------
    always_comb begin
        tx_state_d = tx_state_q;
        w_ti_set   = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: if (w_push) tx_state_d = TX_ARM;
            TX_ARM:  if (!fifo_empty) tx_state_d = TX_BUSY;
            TX_BUSY: begin
                if (!w_push && !fifo_w_en_q && fifo_empty) begin
                    tx_state_d = TX_IDLE;
                    w_ti_set   = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // RX FSM: capture or flag, acknowledge for ACK_CYC cycles, then wait for
    // the level-sensitive rx_valid to drop before accepting another byte.
    // ------------------------------------------------------------------------
    always_comb begin
        rx_state_d = rx_state_q;
        ack_cnt_d  = ack_cnt_q;
        rbuf_d     = rbuf_q;
        w_ri_set   = 1'b0;
        w_ovr_set  = 1'b0;
        rx_ack     = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_valid) begin
                    if (scon_q[REN_BIT] && !scon_q[RI_BIT]) begin
                        rbuf_d   = rx_data;
                        w_ri_set = 1'b1;
                    end else if (scon_q[REN_BIT]) begin
                        w_ovr_set = 1'b1;
                    end
                    ack_cnt_d  = '0;
                    rx_state_d = RX_ACK;
                end
            end
            RX_ACK: begin
                rx_ack = 1'b1;
                if (ack_cnt_q == ACK_LAST) begin
                    ack_cnt_d  = '0;
                    rx_state_d = RX_WAIT;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            RX_WAIT: if (!rx_valid) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Software may only clear the status flags; hardware sets override.
    always_comb begin
        scon_d = scon_q;
        if (sfr.sfr_wr && w_scon_sel) begin
            scon_d = {sfr.sfr_wdata[7:3], scon_q[2:0] & sfr.sfr_wdata[2:0]};
        end
        if (w_ri_set)  scon_d[RI_BIT]  = 1'b1;
        if (w_ti_set)  scon_d[TI_BIT]  = 1'b1;
        if (w_ovr_set) scon_d[OVR_BIT] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q   <= TX_IDLE;
            rx_state_q   <= RX_IDLE;
            scon_q       <= 8'h00;
            rbuf_q       <= 8'h00;
            ack_cnt_q    <= '0;
            fifo_wdata_q <= 8'h00;
            fifo_w_en_q  <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            rx_state_q   <= rx_state_d;
            scon_q       <= scon_d;
            rbuf_q       <= rbuf_d;
            ack_cnt_q    <= ack_cnt_d;
            fifo_wdata_q <= fifo_wdata_d;
            fifo_w_en_q  <= fifo_w_en_d;
        end
    end

    assign fifo_wdata = fifo_wdata_q;
    assign fifo_w_en  = fifo_w_en_q;
    assign uart_irq   = scon_q[TI_BIT] | scon_q[RI_BIT];

endmodule

`default_nettype wire

// File: tb/tb_uart_sfr_ctrl.sv
// ============================================================================
//  Module      : tb_uart_sfr_ctrl
//  Description : Directed plus randomized self-checking bench for uart_sfr_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_sfr_ctrl;

    localparam logic [7:0] SCON = 8'h98;
    localparam logic [7:0] SBUF = 8'h99;
    localparam int         ACKN = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] fifo_wdata;
    logic       fifo_w_en;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       uart_irq;

    uart_sfr_ctrl_if sif ();

    uart_sfr_ctrl #(
        .SCON_ADDR (SCON),
        .SBUF_ADDR (SBUF),
        .ACK_CYC   (ACKN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sfr        (sif),
        .fifo_wdata (fifo_wdata),
        .fifo_w_en  (fifo_w_en),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .uart_irq   (uart_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference state: what software should see in SCON and SBUF.
    logic [7:0] m_scon;
    logic [7:0] m_rbuf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
        sif.sfr_addr = a;
        sif.sfr_rd   = 1'b1;
        #1;
        d = sif.sfr_rdata;
        sif.sfr_rd   = 1'b0;
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        sif.sfr_addr  = a;
        sif.sfr_wdata = d;
        sif.sfr_wr    = 1'b1;
        tick();
        sif.sfr_wr    = 1'b0;
    endtask

    // Flags are clear-only from software; other bits follow the written data.
    function automatic void model_scon_write(input logic [7:0] w);
        for (int b = 0; b < 8; b++) begin
            if (b <= 2) m_scon[b] = m_scon[b] && w[b];
            else        m_scon[b] = w[b];
        end
    endfunction

    // One received byte as seen by software.
    function automatic void model_rx(input logic [7:0] d);
        if (m_scon[4]) begin
            if (m_scon[0]) m_scon[2] = 1'b1;
            else begin
                m_rbuf    = d;
                m_scon[0] = 1'b1;
            end
        end
    endfunction

    task automatic count_ack(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (rx_ack) c++;
        end
    endtask

    task automatic check_regs(input string tag);
        logic [7:0] d;
        sfr_read(SCON, d);
        chk({tag, "_scon"}, d, m_scon);
        sfr_read(SBUF, d);
        chk({tag, "_sbuf"}, d, m_rbuf);
        chk({tag, "_irq"}, uart_irq, m_scon[0] | m_scon[1]);
    endtask

    // Push a byte and let the external FIFO fill then drain.
    task automatic push_and_drain(input logic [7:0] d, input string tag);
        sfr_write(SBUF, d);
        chk({tag, "_wen1"}, fifo_w_en, 1'b1);
        chk({tag, "_wdata"}, fifo_wdata, d);
        fifo_empty = 1'b0;
        tick();
        chk({tag, "_wen0"}, fifo_w_en, 1'b0);
        fifo_empty = 1'b1;
        tick();
        m_scon[1] = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] a;
        int         c;
        int         op;

        rst_n         = 1'b0;
        sif.sfr_addr  = SCON;
        sif.sfr_wr    = 1'b0;
        sif.sfr_rd    = 1'b0;
        sif.sfr_wdata = 8'h00;
        fifo_full     = 1'b0;
        fifo_empty    = 1'b1;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        m_scon        = 8'h00;
        m_rbuf        = 8'h00;
        tick();
        tick();

        // Reset state; combinational outputs still follow inputs in reset.
        chk("rst_wen", fifo_w_en, 1'b0);
        chk("rst_wdata", fifo_wdata, 8'h00);
        chk("rst_ack", rx_ack, 1'b0);
        chk("rst_irq", uart_irq, 1'b0);
        sif.sfr_addr = SBUF;
        #1;
        chk("rst_hit", sif.sfr_hit, 1'b1);
        sfr_read(SCON, d);
        chk("rst_scon", d, 8'h00);
        rst_n = 1'b1;
        tick();

        a = 8'($urandom_range(0, 8'h97));
        sif.sfr_addr = a;
        sif.sfr_rd   = 1'b1;
        #1;
        chk("miss_hit", sif.sfr_hit, 1'b0);
        chk("miss_rdata", sif.sfr_rdata, 8'h00);
        sif.sfr_rd = 1'b0;

        // Simple transmit: push, fill, drain -> TI.
        push_and_drain(8'hA5, "tx_a5");
        check_regs("tx_a5");
        sfr_write(SCON, 8'h10);
        model_scon_write(8'h10);
        check_regs("clr_ti");

        // Back-pressure: three stalled cycles, then one push.
        d = 8'($urandom);
        fifo_full     = 1'b1;
        sif.sfr_addr  = SBUF;
        sif.sfr_wdata = d;
        sif.sfr_wr    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_stall", sif.stall, 1'b1);
            chk("full_nopush", fifo_w_en, 1'b0);
            tick();
        end
        chk("full_nopush_end", fifo_w_en, 1'b0);
        fifo_full = 1'b0;
        #1;
        chk("unstall", sif.stall, 1'b0);
        tick();
        sif.sfr_wr = 1'b0;
        chk("late_push", fifo_w_en, 1'b1);
        chk("late_data", fifo_wdata, d);
        fifo_empty = 1'b0;
        tick();
        chk("late_single", fifo_w_en, 1'b0);
        fifo_empty = 1'b1;
        tick();
        m_scon[1] = 1'b1;
        check_regs("late_ti");
        sfr_write(SCON, 8'h10);
        model_scon_write(8'h10);

        // Receive with rx_valid held: one capture, ACK_CYC ack cycles.
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        tick();
        model_rx(8'h3C);
        rx_data = 8'($urandom);
        c = 1;
        if (!rx_ack) c = 0;
        begin
            int c2;
            count_ack(4, c2);
            c += c2;
        end
        chk("rx_ack_len", c, ACKN);
        rx_valid = 1'b0;
        tick();
        check_regs("rx_3c");

        // Overrun: second byte while RI set.
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        model_rx(8'h77);
        tick(); tick(); tick();
        check_regs("ovr");
        sfr_write(SCON, 8'h10);
        model_scon_write(8'h10);
        check_regs("ovr_clr");

        // TI hardware set collides with a software clear of SCON.
        sfr_write(SBUF, 8'($urandom));
        fifo_empty = 1'b0;
        tick();
        fifo_empty = 1'b1;
        sfr_write(SCON, 8'h00);
        model_scon_write(8'h00);
        m_scon[1] = 1'b1;
        check_regs("ti_vs_clr");

        // REN=0: byte discarded but still acknowledged.
        rx_data  = 8'($urandom);
        rx_valid = 1'b1;
        count_ack(5, c);
        chk("discard_ack", c, ACKN);
        rx_valid = 1'b0;
        tick();
        check_regs("discard");

        // Reset in the middle of an acknowledge.
        rx_valid = 1'b1;
        tick();
        chk("mid_ack", rx_ack, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_ack", rx_ack, 1'b0);
        chk("async_irq", uart_irq, 1'b0);
        m_scon = 8'h00;
        m_rbuf = 8'h00;
        tick();
        rst_n = 1'b1;
        count_ack(4, c);
        chk("post_rst_ack", c, ACKN);
        rx_valid = 1'b0;
        tick();
        check_regs("post_rst");

        // Randomized mix of SCON writes, receives and transmits.
        for (int it = 0; it < 24; it++) begin
            op = int'($urandom_range(0, 2));
            case (op)
                0: begin
                    d = 8'($urandom);
                    sfr_write(SCON, d);
                    model_scon_write(d);
                end
                1: begin
                    d        = 8'($urandom);
                    rx_data  = d;
                    rx_valid = 1'b1;
                    tick();
                    rx_valid = 1'b0;
                    model_rx(d);
                    tick(); tick(); tick();
                end
                default: begin
                    push_and_drain(8'($urandom), "rnd_tx");
                end
            endcase
            check_regs("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
